mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter LATENCY, default 4, SHALL set cycles from request issue to response (legal range 1..8).
REQ-002 Parameter MEM_WORDS_LOG2, default 15, SHALL set storage depth in 16-bit words.
REQ-003 Parameter BURST_LEN, default 8, SHALL set words per burst (fixed 8; one 16-byte block).
REQ-004 clk  input  1  sole clock, rising edge.
REQ-005 rst_n  input  1  reset; asynchronous, active-low.
REQ-006 req_valid  input  1  initiator presents a request.
REQ-007 req_ready  output  1  responder can accept a request this cycle.
REQ-008 req_wr  input  1  1 = write, 0 = read.
REQ-009 req_burst  input  1  1 = 8-word block read.
REQ-010 req_addr  input  16  byte address; bit 0 ignored.
REQ-011 req_wdata  input  16  write data.
REQ-012 resp_valid  output  1  response word valid this cycle; no backpressure.
REQ-013 resp_rdata  output  16  read data (write data echoed for write acks).
REQ-014 resp_addr  output  16  word-aligned byte address of this response.
REQ-015 resp_last  output  1  final response of a transaction.
REQ-016 busy  output  1  any request issuing or in flight.

Function
REQ-017 Acceptance SHALL occur on a rising edge with req_valid & req_ready high.
REQ-018 Issue FSM SHALL have states IDLE and BURST; req_ready SHALL be 1 in IDLE and 0 in BURST.
REQ-019 An accepted single read or write SHALL issue one pipeline slot in its acceptance cycle; the FSM stays in IDLE.
REQ-020 An accepted write SHALL update storage at that edge; a read issued on any later cycle SHALL return the new value.
REQ-021 Read data SHALL be sampled from storage at issue and carried through the pipeline unchanged.
REQ-022 req_burst with req_wr=1 SHALL be treated as a single write; the burst bit is ignored.
REQ-023 An accepted burst read SHALL force addr[3:0] to 0, issue word 0 in the acceptance cycle, enter BURST, and issue words 1..7 (base+2 .. base+14) on the next 7 consecutive cycles.
REQ-024 A 3-bit burst counter SHALL return the FSM to IDLE after word 7 issues; req_ready SHALL be low for exactly 7 cycles after acceptance.
REQ-025 Each slot SHALL emerge as resp_valid exactly LATENCY cycles after its issue edge, so one issue per cycle yields one response per cycle.
REQ-026 resp_last SHALL be 1 for single responses and for burst word 7, and 0 for burst words 0..6.
REQ-027 Outputs SHALL be 0 whenever resp_valid is 0.
REQ-028 Address bits above MEM_WORDS_LOG2+1 SHALL be ignored (aliasing); resp_addr SHALL report the full 16-bit address with bit 0 cleared.
REQ-029 busy SHALL be 1 when the FSM is in BURST or any pipeline slot is valid.

Reset
REQ-030 While rst_n is low: FSM=IDLE, burst counter=0, all slot valid bits=0, resp_valid=0, resp_rdata=0, resp_addr=0, resp_last=0, busy=0, req_ready=1.
REQ-031 Storage contents SHALL NOT be reset.
REQ-032 Reset mid-burst or with slots in flight SHALL abandon them; no response SHALL appear for them after reset releases.
REQ-033 A write accepted on the same edge that rst_n deasserts SHALL be accepted normally.

Structure
REQ-034 A shared package SHALL hold BURST_LEN, the FSM state enum (IDLE, BURST), and the slot record type {valid, wr, last, addr[15:0], data[15:0]}.
REQ-035 The delay line SHALL be one sub-module, resp_pipe (LATENCY-deep shift of slot records with asynchronous clear).

Verification
REQ-036 Write 0x1234 to 0x0010, then read 0x0010 next cycle -> write ack at T+4 (rdata 0x1234, last=1); read resp at T+5 with rdata 0x1234, addr 0x0010.
REQ-037 Burst read at 0x0036 -> req_ready low for 7 cycles; resp_addr 0x0030, 0x0032 .. 0x003E on 8 consecutive cycles starting 4 cycles after acceptance; resp_last only on 0x003E.
REQ-038 Four back-to-back single reads 0x0100, 0x0102, 0x0104, 0x0106 -> four consecutive responses in the same order, last=1 on each, busy high throughout.
REQ-039 Write request held valid during an active burst -> not accepted until the cycle req_ready returns to 1; storage unchanged until then.
REQ-040 Assert rst_n low after burst word 3 issues -> resp_valid 0 for the rest of the run until new requests; busy 0, req_ready 1 immediately.
REQ-041 req_burst=1 with req_wr=1 at 0x0040, data 0xBEEF -> one ack (last=1) at T+4; a read of 0x0040 returns 0xBEEF; 0x0042 is unchanged.

Source files
------------

// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the mem_responder block.
// Holds the burst geometry, the issue FSM state encoding and the pipeline slot record.
// Also two small address helpers used by the issue logic.
package mem_responder_pkg;

    // One burst is one 16-byte block of 16-bit words.
    localparam int BURST_LEN   = 8;
    localparam int BURST_CNT_W = 3;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_e;

    // One issued word travelling through the response delay line.
    typedef struct packed {
        logic        valid;
        logic        wr;
        logic        last;
        logic [15:0] addr;
        logic [15:0] data;
    } slot_t;

    // Byte address of the 16-bit word containing a.
    function automatic logic [15:0] word_align(input logic [15:0] a);
        return {a[15:1], 1'b0};
    endfunction

    // Byte address of the 16-byte block containing a.
    function automatic logic [15:0] block_base(input logic [15:0] a);
        return {a[15:4], 4'h0};
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bus between an initiator and mem_responder.
// Requests use valid/ready; responses are push-only with no backpressure.
// master = initiator side, slave = responder side.
interface mem_responder_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_wr;
    logic        req_burst;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;

    logic        resp_valid;
    logic [15:0] resp_rdata;
    logic [15:0] resp_addr;
    logic        resp_last;
    logic        busy;

    modport master (
        output req_valid, req_wr, req_burst, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_addr, resp_last, busy
    );

    modport slave (
        input  req_valid, req_wr, req_burst, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_addr, resp_last, busy
    );

endinterface

// File: rtl/mem_responder_resp_pipe.sv
// Fixed delay line for issued slots (the resp_pipe stage of mem_responder).
// Latency: exactly LATENCY cycles from the capture edge to the output stage.
// Backpressure: none; accepts one slot per cycle and always advances.
module mem_responder_resp_pipe
    import mem_responder_pkg::*;
#(
    parameter int LATENCY = 4
) (
    input  logic  clk,
    input  logic  rst_n,
    input  slot_t slot_i,
    output slot_t slot_o,
    output logic  any_vld_o
);

    slot_t stage_q [LATENCY];

    // Shift register of slot records; reset clears every stage so in-flight work is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LATENCY; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= slot_i;
            for (int i = 1; i < LATENCY; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign slot_o = stage_q[LATENCY-1];

    // Any live slot anywhere in the line keeps the block busy.
    always_comb begin
        any_vld_o = 1'b0;
        for (int i = 0; i < LATENCY; i++) begin
            any_vld_o = any_vld_o | stage_q[i].valid;
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Memory model responder: single reads/writes and 8-word block reads over 16-bit storage.
// Latency: each issued word responds LATENCY cycles after its issue edge, one per cycle.
// Backpressure: req_ready drops for the 7 follow-on cycles of a burst; responses cannot be stalled.
module mem_responder #(
    parameter int LATENCY        = 4,
    parameter int MEM_WORDS_LOG2 = 15,
    parameter int BURST_LEN      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    mem_responder_if.slave   bus
);

    import mem_responder_pkg::*;

    localparam int MEM_WORDS = 2 ** MEM_WORDS_LOG2;
    localparam logic [BURST_CNT_W-1:0] LAST_BEAT = BURST_CNT_W'(BURST_LEN - 1);

    // Storage is deliberately left out of reset so contents survive a reset pulse.
    logic [15:0] mem_q [MEM_WORDS];

    state_e                 state_q, state_d;
    logic [BURST_CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]            base_q, base_d;

    slot_t issue;
    slot_t pipe_out;
    logic  pipe_any_vld;
    logic  mem_we;
    logic  req_ready;
    logic  unused_wr;

    // Issue state, burst beat counter and latched block base.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            base_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            base_q  <= base_d;
        end
    end

    // Next-state and issue-slot formation; read data is taken from storage at issue time.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        base_d    = base_q;
        issue     = '0;
        mem_we    = 1'b0;
        req_ready = (state_q == IDLE);

        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    issue.valid = 1'b1;
                    if (bus.req_wr) begin
                        // A write with the burst bit set is still just one word.
                        issue.wr   = 1'b1;
                        issue.last = 1'b1;
                        issue.addr = word_align(bus.req_addr);
                        issue.data = bus.req_wdata;
                        // No storage update while reset is held, even though ready reads high.
                        mem_we     = rst_n;
                    end else if (bus.req_burst) begin
                        base_d     = block_base(bus.req_addr);
                        issue.addr = block_base(bus.req_addr);
                        issue.last = 1'b0;
                        state_d    = BURST;
                        cnt_d      = BURST_CNT_W'(1);
                    end else begin
                        issue.last = 1'b1;
                        issue.addr = word_align(bus.req_addr);
                    end
                end
            end
            BURST: begin
                issue.valid = 1'b1;
                issue.addr  = base_q | {12'h000, cnt_q, 1'b0};
                issue.last  = (cnt_q == LAST_BEAT);
                if (cnt_q == LAST_BEAT) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + BURST_CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        if (issue.valid && !issue.wr) begin
            issue.data = mem_q[issue.addr[MEM_WORDS_LOG2:1]];
        end
    end

    // Storage write port; upper address bits beyond the array alias onto it.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[issue.addr[MEM_WORDS_LOG2:1]] <= issue.data;
        end
    end

    mem_responder_resp_pipe #(
        .LATENCY (LATENCY)
    ) u_resp_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .slot_i    (issue),
        .slot_o    (pipe_out),
        .any_vld_o (pipe_any_vld)
    );

    // The write flag travels with the slot for debug visibility but has no port of its own.
    assign unused_wr = pipe_out.wr;

    assign bus.req_ready  = req_ready;
    assign bus.resp_valid = pipe_out.valid;
    assign bus.resp_rdata = pipe_out.valid ? pipe_out.data : 16'h0000;
    assign bus.resp_addr  = pipe_out.valid ? pipe_out.addr : 16'h0000;
    assign bus.resp_last  = pipe_out.valid & pipe_out.last;
    assign bus.busy       = (state_q == BURST) | pipe_any_vld;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: writes/reads, bursts, held requests, reset abandonment.
// Responses are logged on the falling edge tagged with the rising edge that samples them.
// Expected values are hand-derived from the request sequence.
module tb_mem_responder;

    localparam int LAT = 4;

    typedef struct {
        int          edge_n;
        logic [15:0] addr;
        logic [15:0] data;
        logic        last;
    } rsp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   n_vec = 0;
    int   n_mis = 0;
    int   zero_viol = 0;
    int   t0, ta, tw, tr, low, busy_low;
    rsp_t q[$];

    mem_responder_if bus();

    mem_responder #(
        .LATENCY        (LAT),
        .MEM_WORDS_LOG2 (15),
        .BURST_LEN      (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Response logger; also flags any non-zero output while resp_valid is low.
    always @(negedge clk) begin
        rsp_t r;
        if (bus.resp_valid === 1'b1) begin
            r.edge_n = cyc + 1;
            r.addr   = bus.resp_addr;
            r.data   = bus.resp_rdata;
            r.last   = bus.resp_last;
            q.push_back(r);
        end else if (bus.resp_rdata !== 16'h0 || bus.resp_addr !== 16'h0 || bus.resp_last !== 1'b0) begin
            zero_viol++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic chk_rsp(input string tag, input int idx, input int edge_n,
                           input logic [15:0] a, input logic [15:0] d, input logic last);
        if (idx >= q.size()) begin
            chk({tag, "_present"}, q.size(), idx + 1);
            return;
        end
        chk({tag, "_edge"}, q[idx].edge_n, edge_n);
        chk({tag, "_addr"}, q[idx].addr, a);
        chk({tag, "_data"}, q[idx].data, d);
        chk({tag, "_last"}, q[idx].last, last);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle_bus();
        bus.req_valid = 1'b0;
        bus.req_wr    = 1'b0;
        bus.req_burst = 1'b0;
        bus.req_addr  = 16'h0;
        bus.req_wdata = 16'h0;
    endtask

    task automatic drive(input logic wr, input logic burst, input logic [15:0] a, input logic [15:0] d);
        bus.req_valid = 1'b1;
        bus.req_wr    = wr;
        bus.req_burst = burst;
        bus.req_addr  = a;
        bus.req_wdata = d;
    endtask

    task automatic drain(input int n);
        idle_bus();
        repeat (n) tick();
    endtask

    task automatic write_word(input logic [15:0] a, input logic [15:0] d);
        drive(1'b1, 1'b0, a, d);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_bus();
        rst_n = 1'b0;
        repeat (3) tick();
        chk("rst_valid", bus.resp_valid, 1'b0);
        chk("rst_rdata", bus.resp_rdata, 16'h0);
        chk("rst_addr",  bus.resp_addr,  16'h0);
        chk("rst_last",  bus.resp_last,  1'b0);
        chk("rst_busy",  bus.busy,       1'b0);
        chk("rst_ready", bus.req_ready,  1'b1);
        rst_n = 1'b1;
        tick();

        // Write then read of the same word on the next cycle.
        q.delete();
        drive(1'b1, 1'b0, 16'h0010, 16'h1234);
        tick();
        t0 = cyc;
        drive(1'b0, 1'b0, 16'h0010, 16'h0);
        tick();
        drain(8);
        chk("A_cnt", q.size(), 2);
        chk_rsp("A_wack", 0, t0 + LAT,     16'h0010, 16'h1234, 1'b1);
        chk_rsp("A_rd",   1, t0 + 1 + LAT, 16'h0010, 16'h1234, 1'b1);

        // Burst read from a mid-block address, with a write held pending throughout.
        for (int i = 0; i < 8; i++) write_word(16'h0030 + 16'(2 * i), 16'hA000 + 16'(i));
        drain(6);
        q.delete();
        drive(1'b0, 1'b1, 16'h0036, 16'h0);
        tick();
        ta = cyc;
        drive(1'b1, 1'b0, 16'h0038, 16'hC0DE);
        low = 0;
        while (bus.req_ready !== 1'b1 && low < 20) begin
            low++;
            tick();
        end
        chk("B_ready_low", low, 7);
        tick();
        tw = cyc;
        chk("B_wr_edge", tw, ta + 8);
        drain(8);
        chk("B_cnt", q.size(), 9);
        for (int i = 0; i < 8; i++) begin
            chk_rsp("B_burst", i, ta + LAT + i, 16'h0030 + 16'(2 * i), 16'hA000 + 16'(i), (i == 7));
        end
        chk_rsp("B_wack", 8, tw + LAT, 16'h0038, 16'hC0DE, 1'b1);
        q.delete();
        drive(1'b0, 1'b0, 16'h0038, 16'h0);
        tick();
        tr = cyc;
        drain(6);
        chk_rsp("B_rdback", 0, tr + LAT, 16'h0038, 16'hC0DE, 1'b1);

        // Four back-to-back single reads.
        for (int i = 0; i < 4; i++) write_word(16'h0100 + 16'(2 * i), 16'h5500 + 16'(i));
        drain(6);
        q.delete();
        busy_low = 0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, 16'h0100 + 16'(2 * i), 16'h0);
            tick();
            if (i == 0) tr = cyc;
            if (bus.busy !== 1'b1) busy_low++;
        end
        idle_bus();
        repeat (3) begin
            tick();
            if (bus.busy !== 1'b1) busy_low++;
        end
        chk("C_busy_high", busy_low, 0);
        tick();
        chk("C_busy_drop", bus.busy, 1'b0);
        drain(2);
        chk("C_cnt", q.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk_rsp("C_rd", i, tr + LAT + i, 16'h0100 + 16'(2 * i), 16'h5500 + 16'(i), 1'b1);
        end

        // Write with the burst bit set is a single write; odd read address is word-aligned.
        write_word(16'h0042, 16'h5A5A);
        drain(6);
        q.delete();
        drive(1'b1, 1'b1, 16'h0040, 16'hBEEF);
        tick();
        t0 = cyc;
        chk("D_ready", bus.req_ready, 1'b1);
        drain(6);
        chk("D_cnt", q.size(), 1);
        chk_rsp("D_wack", 0, t0 + LAT, 16'h0040, 16'hBEEF, 1'b1);
        q.delete();
        drive(1'b0, 1'b0, 16'h0040, 16'h0);
        tick();
        tr = cyc;
        drive(1'b0, 1'b0, 16'h0043, 16'h0);
        tick();
        drain(6);
        chk_rsp("D_rd40", 0, tr + LAT,     16'h0040, 16'hBEEF, 1'b1);
        chk_rsp("D_rd43", 1, tr + 1 + LAT, 16'h0042, 16'h5A5A, 1'b1);

        // Reset after burst word 3 issues: everything in flight is dropped, storage survives.
        q.delete();
        drive(1'b0, 1'b1, 16'h0100, 16'h0);
        tick();
        ta = cyc;
        idle_bus();
        repeat (3) tick();
        rst_n = 1'b0;
        #1;
        chk("E_busy",  bus.busy,       1'b0);
        chk("E_ready", bus.req_ready,  1'b1);
        chk("E_valid", bus.resp_valid, 1'b0);
        q.delete();
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (12) tick();
        chk("E_no_rsp", q.size(), 0);
        drive(1'b0, 1'b0, 16'h0102, 16'h0);
        tick();
        tr = cyc;
        drain(6);
        chk_rsp("E_after", 0, tr + LAT, 16'h0102, 16'h5501, 1'b1);

        chk("zero_when_idle", zero_viol, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
